// File: rtl/handshake_constant_seq_if.sv
// Handshake bundle for handshake_constant_seq: control token channel in, constant token channel out.
// The master modport drives control and consumes constants; the slave modport is the constant source.
interface handshake_constant_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 2
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [SEL_WIDTH-1:0]  ctrl_sel;
  logic                  seq_restart;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  sel_err;

  modport master (
    output ctrl_valid, ctrl_sel, seq_restart, outs_ready,
    input  ctrl_ready, outs, outs_valid, sel_err
  );

  modport slave (
    input  ctrl_valid, ctrl_sel, seq_restart, outs_ready,
    output ctrl_ready, outs, outs_valid, sel_err
  );
endinterface

// File: rtl/handshake_constant_seq.sv
// Elastic constant source: each control token emits one table entry (cyclic or indexed)
// through a 2-entry skid buffer, so ctrl_ready never depends combinationally on outs_ready.
module handshake_constant_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONSTS = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int MODE       = 0,
  parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONSTS = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  handshake_constant_seq_if.slave hs
);

  localparam int SW1 = SEL_WIDTH + 1;
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_CONSTS - 1);

  // Indices at or beyond NUM_CONSTS match no entry and read as zero.
  function automatic logic [DATA_WIDTH-1:0] table_entry(input logic [SEL_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CONSTS; i++) begin
      v = (idx == SEL_WIDTH'(i)) ? CONSTS[i*DATA_WIDTH +: DATA_WIDTH] : v;
    end
    return v;
  endfunction

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [SEL_WIDTH-1:0]  ptr_q,        ptr_d;
  logic                  sel_err_q,    sel_err_d;

  logic                  accept_s;
  logic                  fire_s;
  logic [SEL_WIDTH-1:0]  ptr_base_s;
  logic [SEL_WIDTH-1:0]  sel_idx_s;
  logic                  sel_oob_s;
  logic [DATA_WIDTH-1:0] value_s;

  // Next-state: value selection, sequence pointer, skid buffer and sticky error.
  always_comb begin
    accept_s     = hs.ctrl_valid && !skid_valid_q;
    fire_s       = main_valid_q && hs.outs_ready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    ptr_d        = ptr_q;

    if (MODE == 0) begin
      // Restart wins over the current pointer, even for a token accepted this cycle.
      ptr_base_s = hs.seq_restart ? '0 : ptr_q;
      sel_idx_s  = ptr_base_s;
      sel_oob_s  = 1'b0;
      if (accept_s) begin
        ptr_d = (ptr_base_s == LAST_IDX) ? '0 : ptr_base_s + SEL_WIDTH'(1);
      end else begin
        ptr_d = ptr_base_s;
      end
    end else begin
      ptr_base_s = ptr_q;
      sel_idx_s  = hs.ctrl_sel;
      sel_oob_s  = ({1'b0, hs.ctrl_sel} >= SW1'(NUM_CONSTS));
    end

    value_s   = table_entry(sel_idx_s);
    sel_err_d = sel_err_q || (accept_s && sel_oob_s);

    if (accept_s) begin
      if (!main_valid_q || fire_s) begin
        main_valid_d = 1'b1;
        main_data_d  = value_s;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = value_s;
      end
    end else if (fire_s) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  // State registers; reset discards every buffered token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ptr_q        <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ptr_q        <= ptr_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign hs.outs       = main_data_q;
  assign hs.outs_valid = main_valid_q;
  assign hs.ctrl_ready = !skid_valid_q;
  assign hs.sel_err    = sel_err_q;

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: a cyclic instance and an indexed instance driven side by side,
// checked every cycle against a queue-based token model plus directed value checks.
module tb_handshake_constant_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam logic [3*18-1:0] TABLE = {18'h00003, 18'h00002, 18'h33F22};

  handshake_constant_seq_if #(.DATA_WIDTH(18), .SEL_WIDTH(2)) if0 ();
  handshake_constant_seq_if #(.DATA_WIDTH(18), .SEL_WIDTH(2)) if1 ();

  handshake_constant_seq #(.DATA_WIDTH(18), .NUM_CONSTS(3), .SEL_WIDTH(2), .MODE(0), .CONSTS(TABLE))
    u_seq (.clk(clk), .rst(rst), .hs(if0.slave));
  handshake_constant_seq #(.DATA_WIDTH(18), .NUM_CONSTS(3), .SEL_WIDTH(2), .MODE(1), .CONSTS(TABLE))
    u_idx (.clk(clk), .rst(rst), .hs(if1.slave));

  logic [17:0] tbl [3] = '{18'h33F22, 18'h00002, 18'h00003};
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];
  int          ptr0;
  logic        err1;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge: check outputs, drive inputs, advance the model one cycle.
  task automatic step(input logic cv0, input logic rs0, input logic or0,
                      input logic cv1, input logic [1:0] sel1, input logic or1);
    logic acc0, fire0, acc1, fire1;
    int   base;
    check_eq("seq_valid", if0.outs_valid, q0.size() > 0);
    check_eq("seq_ready", if0.ctrl_ready, q0.size() < 2);
    check_eq("seq_err",   if0.sel_err, 1'b0);
    if (q0.size() > 0) check_eq("seq_outs", if0.outs, q0[0]);
    check_eq("idx_valid", if1.outs_valid, q1.size() > 0);
    check_eq("idx_ready", if1.ctrl_ready, q1.size() < 2);
    check_eq("idx_err",   if1.sel_err, err1);
    if (q1.size() > 0) check_eq("idx_outs", if1.outs, q1[0]);

    if0.ctrl_valid  = cv0;
    if0.seq_restart = rs0;
    if0.outs_ready  = or0;
    if0.ctrl_sel    = 2'($urandom_range(0, 3));
    if1.ctrl_valid  = cv1;
    if1.ctrl_sel    = sel1;
    if1.outs_ready  = or1;
    if1.seq_restart = 1'($urandom_range(0, 1));

    acc0  = cv0 && (q0.size() < 2);
    fire0 = (q0.size() > 0) && or0;
    if (fire0) void'(q0.pop_front());
    base = rs0 ? 0 : ptr0;
    if (acc0) begin
      q0.push_back(tbl[base]);
      ptr0 = (base + 1) % 3;
    end else begin
      ptr0 = base;
    end

    acc1  = cv1 && (q1.size() < 2);
    fire1 = (q1.size() > 0) && or1;
    if (fire1) void'(q1.pop_front());
    if (acc1) begin
      if (sel1 < 2'd3) q1.push_back(tbl[sel1]);
      else begin
        q1.push_back(18'h0);
        err1 = 1'b1;
      end
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    ptr0 = 0;
    err1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if0.ctrl_valid = 1'b0; if0.seq_restart = 1'b0; if0.outs_ready = 1'b0; if0.ctrl_sel = 2'd0;
    if1.ctrl_valid = 1'b0; if1.seq_restart = 1'b0; if1.outs_ready = 1'b0; if1.ctrl_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  logic [17:0] stream_exp [5] = '{18'h33F22, 18'h00002, 18'h00003, 18'h33F22, 18'h00002};

  initial begin
    do_reset();
    check_eq("rst_valid", if0.outs_valid, 1'b0);
    check_eq("rst_outs",  if0.outs, 18'h0);
    check_eq("rst_ready", if0.ctrl_ready, 1'b1);
    check_eq("rst_err",   if1.sel_err, 1'b0);

    // Single token: one cycle latency
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    check_eq("t1_valid", if0.outs_valid, 1'b1);
    check_eq("t1_outs",  if0.outs, 18'h33F22);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Streaming with wrap, no bubbles
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
      check_eq("t2_valid", if0.outs_valid, 1'b1);
      check_eq("t2_outs",  if0.outs, stream_exp[i]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Backpressure fills both slots, then drains in order
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    check_eq("t3_ready_low", if0.ctrl_ready, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    check_eq("t3_hold", if0.outs, 18'h33F22);
    check_eq("t3_still_low", if0.ctrl_ready, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    check_eq("t3_drain2", if0.outs, 18'h00002);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    check_eq("t3_third", if0.outs, 18'h00003);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Restart colliding with accept
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    check_eq("t4_restart", if0.outs, 18'h33F22);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    check_eq("t4_next", if0.outs, 18'h00002);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Indexed mode with an out-of-range select
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
    check_eq("t5_sel1", if1.outs, 18'h00002);
    check_eq("t5_err0", if1.sel_err, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1);
    check_eq("t5_oob_valid", if1.outs_valid, 1'b1);
    check_eq("t5_oob_outs",  if1.outs, 18'h0);
    check_eq("t5_err1",      if1.sel_err, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1);
    check_eq("t5_err_sticky", if1.sel_err, 1'b1);

    // Async reset with both slots full
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    check_eq("t6_full0", if0.ctrl_ready, 1'b0);
    check_eq("t6_full1", if1.ctrl_ready, 1'b0);
    if0.ctrl_valid = 1'b0;
    if1.ctrl_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_v0", if0.outs_valid, 1'b0);
    check_eq("t6_async_v1", if1.outs_valid, 1'b0);
    check_eq("t6_async_r0", if0.ctrl_ready, 1'b1);
    check_eq("t6_async_err", if1.sel_err, 1'b0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    check_eq("t6_ptr0", if0.outs, 18'h33F22);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Randomized traffic against the token model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_constant_seq.md
Name: handshake_constant_seq

Overview:
Parametrised elastic constant source for the Dynamatic-style dataflow netlist. It generalises the single-constant handshake constant in three ways:
- holds a table of NUM_CONSTS constants;
- each control token emits one entry, either in cyclic sequence (MODE 0) or by index carried on the control channel (MODE 1);
- the output is registered through a 2-entry skid buffer, so ctrl_ready does not depend combinationally on outs_ready and no combinational path exists from ctrl to outs.

Parameters:
DATA_WIDTH, 32, width of each constant and of outs.
NUM_CONSTS, 4, number of table entries; legal range 1..2**SEL_WIDTH.
SEL_WIDTH, 2, width of ctrl_sel and of the internal sequence pointer.
MODE, 0, 0 = cyclic sequence (ctrl_sel ignored), 1 = indexed by ctrl_sel.
CONSTS, all zeros, packed table of width NUM_CONSTS*DATA_WIDTH; entry i = CONSTS[i*DATA_WIDTH +: DATA_WIDTH].

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
ctrl_valid  input  1  control token valid
ctrl_ready  output  1  control token accepted when ctrl_valid && ctrl_ready
ctrl_sel  input  SEL_WIDTH  table index (MODE 1 only)
seq_restart  input  1  synchronous pointer restart (MODE 0 only)
outs  output  DATA_WIDTH  emitted constant
outs_valid  output  1  output token valid
outs_ready  input  1  downstream ready
sel_err  output  1  sticky: an out-of-range ctrl_sel was accepted

Behaviour:
- Reset (async assert, sync deassert by the environment) sets:
  - main_valid = 0, skid_valid = 0, main/skid data = 0;
  - pointer = 0, sel_err = 0;
  - therefore outs_valid = 0, outs = 0, ctrl_ready = 1 one cycle after reset is released.
- Reset mid-operation discards all buffered tokens. No token is emitted afterwards.
- accept = ctrl_valid && ctrl_ready; fire = outs_valid && outs_ready.
- Value selection at accept:
  - MODE 0: entry[pointer].
  - MODE 1: entry[ctrl_sel], or all-zeros if ctrl_sel >= NUM_CONSTS. In the out-of-range case sel_err is set and stays set until reset.
- Sequence pointer (MODE 0 only):
  - advances by 1 on each accept and wraps from NUM_CONSTS-1 to 0;
  - NUM_CONSTS = 1 keeps it at 0.
- seq_restart (MODE 0 only):
  - without accept: next pointer = 0;
  - with accept in the same cycle: restart has priority, the token takes entry 0 and the next pointer = 1 mod NUM_CONSTS;
  - ignored in MODE 1.
- Skid buffer:
  - outs = main data, outs_valid = main_valid, ctrl_ready = !skid_valid (registered).
  - Accept when main is empty or firing: value goes to main, next main_valid = 1.
  - Accept while main is valid and not firing: value goes to skid, next skid_valid = 1, and ctrl_ready drops the next cycle.
  - Fire while skid is valid: skid moves to main, skid_valid clears. New accepts are blocked that cycle because ctrl_ready = 0.
  - Fire with no accept and skid empty: main_valid clears.
- Latency: accept to outs_valid is exactly 1 cycle when main is empty.
- Throughput: 1 token/cycle sustained while outs_ready = 1.
- Tokens are never dropped or duplicated. Output order equals accept order.
- outs is stable while outs_valid = 1 and outs_ready = 0.

Test Plan:
1. Reset, then a single token. Setup: DATA_WIDTH=18, NUM_CONSTS=3, MODE 0, CONSTS = {18'h00003, 18'h00002, 18'h33F22}, outs_ready=1.
   - Stimulus: one ctrl token.
   - Required: outs = 18'h33F22 with outs_valid=1 exactly one cycle after accept.
2. Streaming wrap. Same setup, ctrl_valid held high for 5 cycles.
   - Required: outs sequence 33F22, 00002, 00003, 33F22, 00002, with no bubbles.
3. Backpressure. Same setup, outs_ready=0 while 3 tokens are offered.
   - Required: 2 tokens accepted, ctrl_ready=0 from the cycle after the 2nd accept, outs held at 33F22.
   - Then release outs_ready: 33F22 and 00002 drain in order, and the 3rd token (00003) follows.
4. Restart collision. Same setup, pointer at 2.
   - Stimulus: seq_restart and accept in the same cycle.
   - Required: that token emits 33F22 and the next token emits 00002.
5. MODE 1 out-of-range. MODE 1, NUM_CONSTS=3.
   - Stimulus: ctrl_sel = 1, then ctrl_sel = 3.
   - Required: outs = 00002, then outs = 0; sel_err rises after the second accept and stays high until rst.
6. Async reset mid-operation. Assert rst while both buffer slots are full.
   - Required: outs_valid = 0 immediately without waiting for clk, pointer = 0, sel_err = 0, and no stale token after rst is released.
